// File: rtl/div_iterative_unit.sv
// Iterative restoring divider: one quotient bit per clock, signed or unsigned.
// Magnitudes are divided and the signs are applied on the finishing edge.
module div_iterative_unit #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1,
    parameter int CNT_W  = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_inputRDY,
    output logic             data_resultRDY
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quo;       // remaining dividend bits shift out as quotient bits shift in
    logic [WIDTH-1:0] pr;
    logic [WIDTH-1:0] b_abs;
    logic             sign_q, sign_r, exc_pend;

    logic             accept, sign_a, sign_b, div_zero, ovf, q_bit;
    logic [WIDTH-1:0] a_abs, b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             unused_diff;

    always_comb begin
        accept   = ctrl_DIV && (state != BUSY);
        sign_a   = SIGNED ? data_operandA[WIDTH-1] : 1'b0;
        sign_b   = SIGNED ? data_operandB[WIDTH-1] : 1'b0;
        a_abs    = sign_a ? -data_operandA : data_operandA;
        b_mag    = sign_b ? -data_operandB : data_operandB;
        div_zero = (data_operandB == '0);
        ovf      = SIGNED && (data_operandA == MIN) && (data_operandB == '1);
        shifted  = {pr, quo[WIDTH-1]};
        diff     = {1'b0, shifted} - {2'b00, b_abs};
        q_bit    = ~diff[WIDTH+1];
    end

    // shifted < 2*|B| always, so a non-negative difference never needs bit WIDTH
    assign unused_diff = diff[WIDTH];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = accept ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    assign data_inputRDY  = (state != BUSY);
    assign data_resultRDY = (state == DONE);

    // Exceptions preload the final quotient/remainder and jump the counter to
    // LAST, so they finish through the same output edge as a normal op.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt            <= '0;
            quo            <= '0;
            pr             <= '0;
            b_abs          <= '0;
            sign_q         <= 1'b0;
            sign_r         <= 1'b0;
            exc_pend       <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
        end else if (accept) begin
            b_abs <= b_mag;
            if (div_zero) begin
                quo      <= '0;
                pr       <= data_operandA;
                sign_q   <= 1'b0;
                sign_r   <= 1'b0;
                cnt      <= LAST;
                exc_pend <= 1'b1;
            end else if (ovf) begin
                quo      <= MIN;
                pr       <= '0;
                sign_q   <= 1'b0;
                sign_r   <= 1'b0;
                cnt      <= LAST;
                exc_pend <= 1'b1;
            end else begin
                quo            <= a_abs;
                pr             <= '0;
                sign_q         <= sign_a ^ sign_b;
                sign_r         <= sign_a;
                cnt            <= '0;
                exc_pend       <= 1'b0;
                data_exception <= 1'b0;
            end
        end else if (state == BUSY) begin
            if (cnt == LAST) begin
                data_result    <= sign_q ? -quo : quo;
                data_remainder <= sign_r ? -pr : pr;
                data_exception <= exc_pend;
            end else begin
                pr  <= q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], q_bit};
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
